// File: rtl/exec_alu_unit_pkg.sv
// Shared encodings for the execute-stage ALU: controller opcodes, function
// field codes, BSHFL sub-op codes and the internal ALU control enum.
package exec_alu_unit_pkg;

   // Controller ALU opcodes
   localparam logic [4:0] ALUOP_RTYPE    = 5'd0;
   localparam logic [4:0] ALUOP_ADD      = 5'd1;
   localparam logic [4:0] ALUOP_AND      = 5'd2;
   localparam logic [4:0] ALUOP_OR       = 5'd3;
   localparam logic [4:0] ALUOP_XOR      = 5'd4;
   localparam logic [4:0] ALUOP_SLT      = 5'd5;
   localparam logic [4:0] ALUOP_SLTU     = 5'd6;
   localparam logic [4:0] ALUOP_LUI      = 5'd7;
   localparam logic [4:0] ALUOP_SUB      = 5'd8;
   localparam logic [4:0] ALUOP_SPECIAL2 = 5'd9;
   localparam logic [4:0] ALUOP_SPECIAL3 = 5'd10;

   // R-type function codes
   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_SLLV  = 6'h04;
   localparam logic [5:0] F_SRLV  = 6'h06;
   localparam logic [5:0] F_SRAV  = 6'h07;
   localparam logic [5:0] F_JR    = 6'h08;
   localparam logic [5:0] F_MOVZ  = 6'h0A;
   localparam logic [5:0] F_MOVN  = 6'h0B;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   // SPECIAL2 function codes
   localparam logic [5:0] S2_MADD = 6'h00;
   localparam logic [5:0] S2_MUL  = 6'h02;
   localparam logic [5:0] S2_MSUB = 6'h04;

   // SPECIAL3 BSHFL function and sub-op (Shamt) codes
   localparam logic [5:0] S3_BSHFL = 6'h20;
   localparam logic [4:0] BSHFL_SEB = 5'h10;
   localparam logic [4:0] BSHFL_SEH = 5'h18;

   typedef enum logic [4:0] {
      CTL_ZERO, CTL_ADD, CTL_SUB, CTL_AND, CTL_OR, CTL_XOR, CTL_NOR,
      CTL_SLT, CTL_SLTU, CTL_SLL, CTL_SRL, CTL_ROTR, CTL_SRA,
      CTL_SLLV, CTL_SRLV, CTL_ROTRV, CTL_SRAV, CTL_MOVZ, CTL_MOVN,
      CTL_MFHI, CTL_MFLO, CTL_MTHI, CTL_MTLO, CTL_MULT, CTL_MULTU,
      CTL_MUL, CTL_MADD, CTL_MSUB, CTL_LUI, CTL_SEB, CTL_SEH
   } alu_ctl_e;

endpackage

// File: rtl/exec_alu_unit_control.sv
// ALU control decode: opcode/funct/sub-op fields to the internal control
// enum plus the HI/LO write and MUL result-select flags.
module exec_alu_unit_control
   import exec_alu_unit_pkg::*;
(
   input  logic [4:0] ALUOp,
   input  logic [5:0] Funct,
   input  logic [4:0] Shamt,
   input  logic       rs_lsb,
   output alu_ctl_e   ctl,
   output logic       HiLoWrite,
   output logic       MultBit
);

   // Decode the operation; anything unrecognised yields a zero result
   always_comb begin
      ctl       = CTL_ZERO;
      HiLoWrite = 1'b0;
      MultBit   = 1'b0;
      case (ALUOp)
         ALUOP_RTYPE: begin
            case (Funct)
               F_ADD, F_ADDU: ctl = CTL_ADD;
               F_SUB, F_SUBU: ctl = CTL_SUB;
               F_AND:         ctl = CTL_AND;
               F_OR:          ctl = CTL_OR;
               F_XOR:         ctl = CTL_XOR;
               F_NOR:         ctl = CTL_NOR;
               F_SLT:         ctl = CTL_SLT;
               F_SLTU:        ctl = CTL_SLTU;
               F_SLL:         ctl = CTL_SLL;
               F_SRL:         ctl = rs_lsb ? CTL_ROTR : CTL_SRL;
               F_SRA:         ctl = CTL_SRA;
               F_SLLV:        ctl = CTL_SLLV;
               F_SRLV:        ctl = Shamt[0] ? CTL_ROTRV : CTL_SRLV;
               F_SRAV:        ctl = CTL_SRAV;
               F_MOVZ:        ctl = CTL_MOVZ;
               F_MOVN:        ctl = CTL_MOVN;
               F_MFHI:        ctl = CTL_MFHI;
               F_MFLO:        ctl = CTL_MFLO;
               F_MTHI:        begin ctl = CTL_MTHI;  HiLoWrite = 1'b1; end
               F_MTLO:        begin ctl = CTL_MTLO;  HiLoWrite = 1'b1; end
               F_MULT:        begin ctl = CTL_MULT;  HiLoWrite = 1'b1; end
               F_MULTU:       begin ctl = CTL_MULTU; HiLoWrite = 1'b1; end
               default:       ctl = CTL_ZERO;
            endcase
         end
         ALUOP_ADD:  ctl = CTL_ADD;
         ALUOP_AND:  ctl = CTL_AND;
         ALUOP_OR:   ctl = CTL_OR;
         ALUOP_XOR:  ctl = CTL_XOR;
         ALUOP_SLT:  ctl = CTL_SLT;
         ALUOP_SLTU: ctl = CTL_SLTU;
         ALUOP_LUI:  ctl = CTL_LUI;
         ALUOP_SUB:  ctl = CTL_SUB;
         ALUOP_SPECIAL2: begin
            case (Funct)
               S2_MUL:  begin ctl = CTL_MUL;  MultBit   = 1'b1; end
               S2_MADD: begin ctl = CTL_MADD; HiLoWrite = 1'b1; end
               S2_MSUB: begin ctl = CTL_MSUB; HiLoWrite = 1'b1; end
               default: ctl = CTL_ZERO;
            endcase
         end
         ALUOP_SPECIAL3: begin
            if (Funct == S3_BSHFL && Shamt == BSHFL_SEB)
               ctl = CTL_SEB;
            else if (Funct == S3_BSHFL && Shamt == BSHFL_SEH)
               ctl = CTL_SEH;
         end
         default: ctl = CTL_ZERO;
      endcase
   end

endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage ALU: combinational datapath, multiplier, branch adder and
// the architectural HI/LO register pair.
module exec_alu_unit
   import exec_alu_unit_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  ALUOp,
   input  logic [5:0]  Funct,
   input  logic [4:0]  Shamt,
   input  logic [4:0]  RsField,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [31:0] PCPlus4,
   input  logic [31:0] Offset,
   output logic [31:0] ALUResult,
   output logic        Zero,
   output logic [63:0] MultResult,
   output logic        HiLoWrite,
   output logic        MultBit,
   output logic [31:0] BranchAddress,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   alu_ctl_e    ctl;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] rot_imm;
   logic [63:0] rot_var;
   logic        unused_rs;

   // Only the rotate-select bit of the rs field matters to this stage
   assign unused_rs = ^RsField[4:1];

   exec_alu_unit_control u_control (
      .ALUOp     (ALUOp),
      .Funct     (Funct),
      .Shamt     (Shamt),
      .rs_lsb    (RsField[0]),
      .ctl       (ctl),
      .HiLoWrite (HiLoWrite),
      .MultBit   (MultBit)
   );

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Rotating a doubled word right leaves the rotated value in the low half
   assign rot_imm = {B, B} >> Shamt;
   assign rot_var = {B, B} >> A[4:0];

   assign BranchAddress = PCPlus4 + (Offset << 2);

   // Result, write-permit and 64-bit HI/LO value selection
   always_comb begin
      ALUResult  = 32'd0;
      Zero       = 1'b1;
      MultResult = prod_s;
      case (ctl)
         CTL_ADD:   ALUResult = A + B;
         CTL_SUB:   ALUResult = A - B;
         CTL_AND:   ALUResult = A & B;
         CTL_OR:    ALUResult = A | B;
         CTL_XOR:   ALUResult = A ^ B;
         CTL_NOR:   ALUResult = ~(A | B);
         CTL_SLT:   ALUResult = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
         CTL_SLTU:  ALUResult = (A < B) ? 32'd1 : 32'd0;
         CTL_SLL:   ALUResult = B << Shamt;
         CTL_SRL:   ALUResult = B >> Shamt;
         CTL_ROTR:  ALUResult = rot_imm[31:0];
         CTL_SRA:   ALUResult = $signed(B) >>> Shamt;
         CTL_SLLV:  ALUResult = B << A[4:0];
         CTL_SRLV:  ALUResult = B >> A[4:0];
         CTL_ROTRV: ALUResult = rot_var[31:0];
         CTL_SRAV:  ALUResult = $signed(B) >>> A[4:0];
         CTL_MOVZ:  begin ALUResult = A; Zero = (B == 32'd0); end
         CTL_MOVN:  begin ALUResult = A; Zero = (B != 32'd0); end
         CTL_MFHI:  ALUResult = HI;
         CTL_MFLO:  ALUResult = LO;
         CTL_MTHI:  MultResult = {A, LO};
         CTL_MTLO:  MultResult = {HI, A};
         CTL_MULTU: MultResult = prod_u;
         CTL_MUL:   ALUResult = prod_s[31:0];
         CTL_MADD:  MultResult = {HI, LO} + prod_s;
         CTL_MSUB:  MultResult = {HI, LO} - prod_s;
         CTL_LUI:   ALUResult = B << 16;
         CTL_SEB:   ALUResult = {{24{B[7]}}, B[7:0]};
         CTL_SEH:   ALUResult = {{16{B[15]}}, B[15:0]};
         default:   ALUResult = 32'd0;
      endcase
   end

   // HI/LO pair: cleared asynchronously, loaded when the op writes it
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         HI <= 32'd0;
         LO <= 32'd0;
      end else if (HiLoWrite) begin
         HI <= MultResult[63:32];
         LO <= MultResult[31:0];
      end
   end

endmodule

// File: tb/tb_exec_alu_unit.sv
// Self-checking bench for exec_alu_unit: fixed vector table, hand-written
// HI/LO sequences and randomized vectors against a behavioural model.
module tb_exec_alu_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [4:0]  ALUOp;
   logic [5:0]  Funct;
   logic [4:0]  Shamt;
   logic [4:0]  RsField;
   logic [31:0] A, B, PCPlus4, Offset;
   logic [31:0] ALUResult;
   logic        Zero;
   logic [63:0] MultResult;
   logic        HiLoWrite;
   logic        MultBit;
   logic [31:0] BranchAddress;
   logic [31:0] HI, LO;

   int checks = 0;
   int failures = 0;

   exec_alu_unit dut (
      .Clk(Clk), .Reset(Reset), .ALUOp(ALUOp), .Funct(Funct), .Shamt(Shamt),
      .RsField(RsField), .A(A), .B(B), .PCPlus4(PCPlus4), .Offset(Offset),
      .ALUResult(ALUResult), .Zero(Zero), .MultResult(MultResult),
      .HiLoWrite(HiLoWrite), .MultBit(MultBit), .BranchAddress(BranchAddress),
      .HI(HI), .LO(LO)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [4:0]  op;
      logic [5:0]  funct;
      logic [4:0]  shamt;
      logic [4:0]  rs;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic        exp_hlw;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic [63:0] mres;
      logic        hlw;
      logic        mbit;
   } ref_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [5:0] f, input logic [4:0] sh,
                        input logic [4:0] rs, input logic [31:0] a, input logic [31:0] b);
      ALUOp = op; Funct = f; Shamt = sh; RsField = rs; A = a; B = b;
      #2;
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] v, input int s);
      if (s == 0) return v;
      return (v >> s) | (v << (32 - s));
   endfunction

   // Behavioural model written directly from the instruction semantics
   function automatic ref_t model(input logic [4:0] op, input logic [5:0] f,
                                  input logic [4:0] sh, input logic [4:0] rs,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo);
      ref_t r;
      longint signed sa, sb;
      longint unsigned ua, ub, hl;
      int amt_v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      hl = {hi, lo};
      amt_v = int'(a[4:0]);
      r.res = 0; r.zero = 1; r.mres = sa * sb; r.hlw = 0; r.mbit = 0;
      if (op == 0) begin
         case (f)
            6'h20, 6'h21: r.res = a + b;
            6'h22, 6'h23: r.res = a - b;
            6'h24: r.res = a & b;
            6'h25: r.res = a | b;
            6'h26: r.res = a ^ b;
            6'h27: r.res = ~(a | b);
            6'h2A: r.res = (sa < sb) ? 1 : 0;
            6'h2B: r.res = (ua < ub) ? 1 : 0;
            6'h00: r.res = b << sh;
            6'h02: r.res = rs[0] ? rotr(b, int'(sh)) : (b >> sh);
            6'h03: r.res = 32'(sb >>> sh);
            6'h04: r.res = b << amt_v;
            6'h06: r.res = sh[0] ? rotr(b, amt_v) : (b >> amt_v);
            6'h07: r.res = 32'(sb >>> amt_v);
            6'h0A: begin r.res = a; r.zero = (b == 0); end
            6'h0B: begin r.res = a; r.zero = (b != 0); end
            6'h10: r.res = hi;
            6'h12: r.res = lo;
            6'h11: begin r.mres = {a, lo}; r.hlw = 1; end
            6'h13: begin r.mres = {hi, a}; r.hlw = 1; end
            6'h18: r.hlw = 1;
            6'h19: begin r.mres = ua * ub; r.hlw = 1; end
            default: r.res = 0;
         endcase
      end else if (op == 1) r.res = a + b;
      else if (op == 2) r.res = a & b;
      else if (op == 3) r.res = a | b;
      else if (op == 4) r.res = a ^ b;
      else if (op == 5) r.res = (sa < sb) ? 1 : 0;
      else if (op == 6) r.res = (ua < ub) ? 1 : 0;
      else if (op == 7) r.res = b * 32'h10000;
      else if (op == 8) r.res = a - b;
      else if (op == 9) begin
         if (f == 6'h02) begin r.mbit = 1; r.res = 32'(sa * sb); end
         else if (f == 6'h00) begin r.mres = hl + 64'(sa * sb); r.hlw = 1; end
         else if (f == 6'h04) begin r.mres = hl - 64'(sa * sb); r.hlw = 1; end
      end else if (op == 10 && f == 6'h20) begin
         if (sh == 5'h10) r.res = 32'(longint'($signed(b[7:0])));
         else if (sh == 5'h18) r.res = 32'(longint'($signed(b[15:0])));
      end
      return r;
   endfunction

   vec_t tbl[16];
   logic [31:0] m_hi, m_lo;
   ref_t r;
   logic [5:0] rf_list[25];

   initial begin
      Reset = 1'b1;
      ALUOp = 0; Funct = 0; Shamt = 0; RsField = 0; A = 0; B = 0;
      PCPlus4 = 0; Offset = 0;
      tbl[0]  = '{5'd0,  6'h20, 5'd0,  5'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1'b0};
      tbl[1]  = '{5'd0,  6'h02, 5'd4,  5'd1, 32'h0,        32'h12345678, 32'h81234567, 1'b1, 1'b0};
      tbl[2]  = '{5'd0,  6'h02, 5'd4,  5'd0, 32'h0,        32'h12345678, 32'h01234567, 1'b1, 1'b0};
      tbl[3]  = '{5'd0,  6'h0A, 5'd0,  5'd0, 32'h5,        32'h0,        32'h5,        1'b1, 1'b0};
      tbl[4]  = '{5'd0,  6'h0A, 5'd0,  5'd0, 32'h5,        32'h7,        32'h5,        1'b0, 1'b0};
      tbl[5]  = '{5'd0,  6'h0B, 5'd0,  5'd0, 32'h9,        32'h0,        32'h9,        1'b0, 1'b0};
      tbl[6]  = '{5'd10, 6'h20, 5'h18, 5'd0, 32'h0,        32'h00008001, 32'hFFFF8001, 1'b1, 1'b0};
      tbl[7]  = '{5'd10, 6'h20, 5'h10, 5'd0, 32'h0,        32'h00001280, 32'hFFFFFF80, 1'b1, 1'b0};
      tbl[8]  = '{5'd0,  6'h2A, 5'd0,  5'd0, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b1, 1'b0};
      tbl[9]  = '{5'd6,  6'h00, 5'd0,  5'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
      tbl[10] = '{5'd7,  6'h00, 5'd0,  5'd0, 32'h0,        32'h0000ABCD, 32'hABCD0000, 1'b1, 1'b0};
      tbl[11] = '{5'd0,  6'h27, 5'd0,  5'd0, 32'hF0F00000, 32'h0000000F, 32'h0F0FFFF0, 1'b1, 1'b0};
      tbl[12] = '{5'd0,  6'h07, 5'd0,  5'd0, 32'd8,        32'h80000000, 32'hFF800000, 1'b1, 1'b0};
      tbl[13] = '{5'd0,  6'h08, 5'd0,  5'd0, 32'h1234,     32'h5678,     32'h0,        1'b1, 1'b0};
      tbl[14] = '{5'd11, 6'h20, 5'd0,  5'd0, 32'h1,        32'h2,        32'h0,        1'b1, 1'b0};
      tbl[15] = '{5'd0,  6'h06, 5'd1,  5'd0, 32'd8,        32'h000000AB, 32'hAB000000, 1'b1, 1'b0};

      #3;
      chk("reset_hi", {32'd0, HI}, 64'd0);
      chk("reset_lo", {32'd0, LO}, 64'd0);
      tick();
      Reset = 1'b0;

      // Table-driven combinational vectors
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].op, tbl[i].funct, tbl[i].shamt, tbl[i].rs, tbl[i].a, tbl[i].b);
         chk($sformatf("tbl%0d_res", i), {32'd0, ALUResult}, {32'd0, tbl[i].exp_res});
         chk($sformatf("tbl%0d_zero", i), {63'd0, Zero}, {63'd0, tbl[i].exp_zero});
         chk($sformatf("tbl%0d_hlw", i), {63'd0, HiLoWrite}, {63'd0, tbl[i].exp_hlw});
      end

      PCPlus4 = 32'h100; Offset = 32'hFFFFFFFF; #1;
      chk("branch_neg", {32'd0, BranchAddress}, 64'hFC);
      PCPlus4 = 32'hFFFFFFF0; Offset = 32'h8; #1;
      chk("branch_wrap", {32'd0, BranchAddress}, 64'h10);

      // MUL writes GPR only
      drive(5'd9, 6'h02, 5'd0, 5'd0, 32'hFFFFFFFE, 32'h3);
      chk("mul_res", {32'd0, ALUResult}, 64'hFFFFFFFA);
      chk("mul_bit", {63'd0, MultBit}, 64'd1);
      chk("mul_hlw", {63'd0, HiLoWrite}, 64'd0);

      // MULT then MADD back to zero
      tick();
      drive(5'd0, 6'h18, 5'd0, 5'd0, 32'hFFFFFFFE, 32'h3);
      chk("mult_hlw", {63'd0, HiLoWrite}, 64'd1);
      tick();
      chk("mult_hi", {32'd0, HI}, 64'hFFFFFFFF);
      chk("mult_lo", {32'd0, LO}, 64'hFFFFFFFA);
      drive(5'd9, 6'h00, 5'd0, 5'd0, 32'h2, 32'h3);
      chk("madd_mres", MultResult, 64'd0);
      tick();
      chk("madd_hilo", {HI, LO}, 64'd0);

      // MTHI then asynchronous reset mid-cycle
      drive(5'd0, 6'h11, 5'd0, 5'd0, 32'hAA, 32'h0);
      tick();
      chk("mthi_hi", {32'd0, HI}, 64'hAA);
      drive(5'd0, 6'h10, 5'd0, 5'd0, 32'h0, 32'h0);
      Reset = 1'b1; #1;
      chk("async_rst_hi", {32'd0, HI}, 64'd0);
      chk("mfhi_after_rst", {32'd0, ALUResult}, 64'd0);
      // Writes are ignored while Reset is held across an edge
      drive(5'd0, 6'h13, 5'd0, 5'd0, 32'h55, 32'h0);
      tick();
      chk("rst_blocks_lo", {32'd0, LO}, 64'd0);
      Reset = 1'b0;
      tick();
      chk("post_rst_lo", {32'd0, LO}, 64'h55);

      // Randomized vectors against the model, tracking HI/LO
      m_hi = HI === 32'd0 ? 32'd0 : 32'hDEAD;
      m_lo = 32'h55;
      rf_list = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h0A, 6'h0B,
                  6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h20, 6'h21, 6'h22,
                  6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
      for (int n = 0; n < 400; n++) begin
         logic [4:0] op, sh, rs;
         logic [5:0] f;
         logic [31:0] a, b;
         op = 5'($urandom_range(0, 12));
         f  = 6'($urandom);
         if (op == 0 && $urandom_range(0, 7) != 0) f = rf_list[$urandom_range(0, 24)];
         if (op == 9 && $urandom_range(0, 3) != 0) f = 6'(2 * $urandom_range(0, 2));
         sh = 5'($urandom);
         if (op == 10) begin
            if ($urandom_range(0, 3) != 0) f = 6'h20;
            if ($urandom_range(0, 2) != 0) sh = $urandom_range(0, 1) ? 5'h10 : 5'h18;
         end
         rs = 5'($urandom);
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         PCPlus4 = $urandom; Offset = $urandom;
         drive(op, f, sh, rs, a, b);
         r = model(op, f, sh, rs, a, b, m_hi, m_lo);
         chk($sformatf("rnd%0d_res op=%0d f=%0h", n, op, f), {32'd0, ALUResult}, {32'd0, r.res});
         chk($sformatf("rnd%0d_zero", n), {63'd0, Zero}, {63'd0, r.zero});
         chk($sformatf("rnd%0d_mres op=%0d f=%0h", n, op, f), MultResult, r.mres);
         chk($sformatf("rnd%0d_hlw", n), {63'd0, HiLoWrite}, {63'd0, r.hlw});
         chk($sformatf("rnd%0d_mbit", n), {63'd0, MultBit}, {63'd0, r.mbit});
         chk($sformatf("rnd%0d_br", n), {32'd0, BranchAddress},
             {32'd0, 32'(PCPlus4 + Offset * 4)});
         tick();
         if (r.hlw) begin
            m_hi = r.mres[63:32];
            m_lo = r.mres[31:0];
         end
         chk($sformatf("rnd%0d_hilo", n), {HI, LO}, {m_hi, m_lo});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
